uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue_if.sv | 37 +++
 rtl/uart_tx_queue.sv | 114 +++++++++++
 tb/tb_uart_tx_queue.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Producer/consumer signal bundle for uart_tx_queue. The overflow signal exists
// only when UART_TXQ_OVF_EN is defined.
interface uart_tx_queue_if #(
    parameter int unsigned DEPTH = 16
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          start;
    logic [7:0]    tx_data;
    logic          busy;
`ifdef UART_TXQ_OVF_EN
    logic          overflow;

    modport master (
        output wr_en, wr_data, busy,
        input  full, empty, count, start, tx_data, overflow
    );
    modport slave (
        input  wr_en, wr_data, busy,
        output full, empty, count, start, tx_data, overflow
    );
`else
    modport master (
        output wr_en, wr_data, busy,
        input  full, empty, count, start, tx_data
    );
    modport slave (
        input  wr_en, wr_data, busy,
        output full, empty, count, start, tx_data
    );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a uart_tx: circular buffer plus a launch/ack/done controller.
// Define UART_TXQ_OVF_EN to add the sticky overflow flag for dropped pushes.
module uart_tx_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitDone} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [TW-1:0] ack_cnt_q;
    state_e        state_q;
    logic          start_q;
    logic [7:0]    tx_data_q;

    logic full;
    logic push;
    logic pop;

    // A push against a full queue is dropped even when a pop frees a slot this edge.
    assign full = (count_q == CW'(DEPTH));
    assign push = bus.wr_en & ~full;
    assign pop  = (state_q == StIdle) && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ack_cnt_q <= '0;
            state_q   <= StIdle;
            start_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            start_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        tx_data_q <= mem_q[rd_ptr_q];
                        start_q   <= 1'b1;
                        ack_cnt_q <= '0;
                        state_q   <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    // Downstream that never acknowledges still counts the byte as sent.
                    if (bus.busy) begin
                        ack_cnt_q <= '0;
                        state_q   <= StWaitDone;
                    end else if (ack_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                        ack_cnt_q <= '0;
                        state_q   <= StIdle;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + TW'(1);
                    end
                end
                StWaitDone: begin
                    if (!bus.busy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_en && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.overflow = overflow_q;
`endif

    assign bus.full    = full;
    assign bus.empty   = (count_q == '0);
    assign bus.count   = count_q;
    assign bus.start   = start_q;
    assign bus.tx_data = tx_data_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: pushes record expected bytes, a monitor
// checks every start pulse against them; a small busy model plays uart_tx.
module tb_uart_tx_queue;
    localparam int unsigned DEPTH       = 16;
    localparam int unsigned ACK_TIMEOUT = 8;

    logic clk;
    logic rst_n;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(
        .DEPTH      (DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    // busy model controls
    bit busy_en    = 1'b1;
    int busy_delay = 1;
    int busy_len   = 3;
    int phase      = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (accept) exp_q.push_back(b);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_start(input int budget, output int cyc);
        cyc = 0;
        while (!bus.start && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.start) begin
            total++;
            bad++;
            $display("FAIL start_timeout: got no start in %0d cycles, required a start", budget);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycles(1);
            n++;
        end
        cycles(3);
        while ((phase != 0 || bus.busy) && n < budget) begin
            cycles(1);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d bytes pending, required 0", exp_q.size());
        end
        cycles(ACK_TIMEOUT + 4);
        chk("drain_count", 32'(bus.count), 0);
        chk("drain_empty", 32'(bus.empty), 1);
    endtask

    // uart_tx stand-in: busy rises busy_delay cycles after start, held busy_len cycles
    initial begin
        int dly;
        int hold;
        bus.busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.busy = 1'b0;
                phase    = 0;
            end else begin
                case (phase)
                    0: if (bus.start && busy_en) begin
                        dly   = busy_delay;
                        phase = 1;
                    end
                    1: begin
                        dly--;
                        if (dly <= 0) begin
                            bus.busy = 1'b1;
                            hold     = busy_len;
                            phase    = 2;
                        end
                    end
                    default: begin
                        hold--;
                        if (hold <= 0) begin
                            bus.busy = 1'b0;
                            phase    = 0;
                        end
                    end
                endcase
            end
        end
    end

    // monitor: order, single-cycle pulse, idle gap after a busy frame
    initial begin
        logic       prev_start = 1'b0;
        bit         saw_busy   = 1'b0;
        int         low_streak = 0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.start) begin
                chk("start_width", 32'(prev_start), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got start with tx_data %0h, required none",
                             bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data_order", 32'(bus.tx_data), 32'(e));
                end
                if (saw_busy) begin
                    chk("idle_gap", 32'(low_streak >= 2), 1);
                    saw_busy = 1'b0;
                end
            end
            if (bus.busy) begin
                saw_busy   = 1'b1;
                low_streak = 0;
            end else begin
                low_streak++;
            end
            prev_start = bus.start;
        end
    end

    initial begin
        int c;
        int c2;
        logic [7:0] hello [5];
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C;
        hello[3] = 8'h4C; hello[4] = 8'h4F;

        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        cycles(3);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
`ifdef UART_TXQ_OVF_EN
        chk("rst_overflow", 32'(bus.overflow), 0);
`endif
        rst_n = 1'b1;
        cycles(2);

        // single byte, latency and return to empty
        busy_delay = 1;
        busy_len   = 3;
        push(8'h48, 1'b1);
        chk("push_count", 32'(bus.count), 1);
        chk("push_start_low", 32'(bus.start), 0);
        wait_start(10, c);
        chk("latency", 32'(c), 1);
        chk("single_tx_data", 32'(bus.tx_data), 32'h48);
        chk("pop_count", 32'(bus.count), 0);
        drain(100);

        // HELLO, busy held 10 cycles per frame
        busy_len = 10;
        for (int i = 0; i < 5; i++) push(hello[i], 1'b1);
        drain(300);

        // fill while stalled in WAIT_DONE; the 17th push is dropped
        busy_len = 40;
        push(8'hA0, 1'b1);
        cycles(4);
        for (int i = 0; i < 16; i++) push(8'(8'hB0 + i), 1'b1);
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_count", 32'(bus.count), 16);
        push(8'hEE, 1'b0);
        chk("drop_count", 32'(bus.count), 16);
        chk("drop_full", 32'(bus.full), 1);
`ifdef UART_TXQ_OVF_EN
        chk("overflow_set", 32'(bus.overflow), 1);
`endif
        busy_len = 2;
        drain(600);

        // no busy: ack timeout, next byte launched 9 edges after the first
        busy_en = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        wait_start(10, c);
        cycles(1);
        wait_start(20, c2);
        chk("timeout_gap", 32'(c2 + 1), 32'(ACK_TIMEOUT + 1));
        chk("timeout_tx_data", 32'(bus.tx_data), 32'h22);
        drain(100);
        busy_en = 1'b1;

        // push in the pop cycle with count=1
        push(8'h61, 1'b1);
        push(8'h55, 1'b1);
        chk("pushpop_count", 32'(bus.count), 1);
        drain(100);

        // reset while in WAIT_DONE with 3 bytes queued
        busy_len = 50;
        for (int i = 0; i < 4; i++) push(8'(8'h31 + i), 1'b1);
        cycles(2);
        chk("pre_rst_count", 32'(bus.count), 3);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_start", 32'(bus.start), 0);
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_tx_data", 32'(bus.tx_data), 0);
        chk("mid_rst_empty", 32'(bus.empty), 1);
`ifdef UART_TXQ_OVF_EN
        chk("mid_rst_overflow", 32'(bus.overflow), 0);
`endif
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h99;
        cycles(2);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        cycles(20);
        chk("post_rst_count", 32'(bus.count), 0);
        busy_len = 3;
        push(8'h77, 1'b1);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
